// File: rtl/stats_update_ctrl.sv
// End-of-round statistics updater. It sees the rising edge of round_done and
// captures the finished round. One shared serial restoring divider then
// forms the running means for WPM and accuracy. Best values, averages and the
// round count all change together in COMMIT, so the display never sees a
// partial update.
module stats_update_ctrl #(
  parameter int W     = 10,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             round_done,
  input  logic             clear_stats,
  input  logic [W-1:0]     wpm,
  input  logic [W-1:0]     acc,
  output logic [W-1:0]     wpm_best,
  output logic [W-1:0]     wpm_avg,
  output logic [W-1:0]     acc_best,
  output logic [W-1:0]     acc_avg,
  output logic [CNT_W-1:0] rounds,
  output logic             busy,
  output logic             upd_valid,
  output logic             overrun
);

  localparam int NW    = 15;        // numerator width: 1023*31+1023 fits
  localparam int DW    = CNT_W + 1; // divisor n+1 spans 1..2**CNT_W
  localparam int ITERS = NW;

  typedef enum logic [2:0] {IDLE, CAPTURE, DIV_WPM, DIV_ACC, COMMIT} state_t;

  state_t           state_q, state_d;
  logic             rd_q, start_q;
  logic [3:0]       cnt_q;
  logic [NW-1:0]    quo_q, na_q;
  logic [DW-1:0]    rem_q, d_q;
  logic [W-1:0]     wpm_lat_q, acc_lat_q, qw_q;
  logic [W-1:0]     wpm_best_q, wpm_avg_q, acc_best_q, acc_avg_q;
  logic [CNT_W-1:0] rounds_q;
  logic             upd_q, ovr_q;

  logic             start, last_iter;
  logic [NW-1:0]    nw, na;
  logic [DW:0]      trial;
  logic [DW-1:0]    diff, rem_nx;
  logic             ge;
  logic [NW-1:0]    quo_nx;

  assign busy      = (state_q != IDLE);
  assign start     = round_done & ~rd_q;
  assign last_iter = (cnt_q == 4'(ITERS - 1));

  // Numerators rebuild the running sum from the current mean: avg*n + sample.
  assign nw = NW'(wpm_avg_q) * NW'(rounds_q) + NW'(wpm);
  assign na = NW'(acc_avg_q) * NW'(rounds_q) + NW'(acc);

  // One restoring-division step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    trial  = {rem_q, quo_q[NW-1]};
    ge     = (trial >= {1'b0, d_q});
    diff   = DW'(trial - {1'b0, d_q});
    rem_nx = ge ? diff : trial[DW-1:0];
    quo_nx = {quo_q[NW-2:0], ge};
  end

  // Edge history, registered start and sticky overrun. A start that arrives while busy is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= 1'b0;
      start_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rd_q <= round_done;
      if (clear_stats) begin
        start_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        start_q <= start & ~busy;
        ovr_q   <= ovr_q | (start & busy);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Clear aborts from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_q) state_d = CAPTURE;
      CAPTURE: state_d = DIV_WPM;
      DIV_WPM: if (last_iter) state_d = DIV_ACC;
      DIV_ACC: if (last_iter) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_stats) state_d = IDLE;
  end

  // Datapath: capture, the two serial divisions, then the single commit of all stats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      quo_q      <= '0;
      na_q       <= '0;
      rem_q      <= '0;
      d_q        <= '0;
      wpm_lat_q  <= '0;
      acc_lat_q  <= '0;
      qw_q       <= '0;
      wpm_best_q <= '0;
      wpm_avg_q  <= '0;
      acc_best_q <= '0;
      acc_avg_q  <= '0;
      rounds_q   <= '0;
      upd_q      <= 1'b0;
    end else if (clear_stats) begin
      cnt_q      <= '0;
      quo_q      <= '0;
      na_q       <= '0;
      rem_q      <= '0;
      d_q        <= '0;
      qw_q       <= '0;
      wpm_best_q <= '0;
      wpm_avg_q  <= '0;
      acc_best_q <= '0;
      acc_avg_q  <= '0;
      rounds_q   <= '0;
      upd_q      <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        CAPTURE: begin
          wpm_lat_q <= wpm;
          acc_lat_q <= acc;
          quo_q     <= nw;
          na_q      <= na;
          rem_q     <= '0;
          d_q       <= DW'(rounds_q) + DW'(1);
          cnt_q     <= '0;
        end
        DIV_WPM: begin
          if (last_iter) begin
            // Quotient is at most 1023 here, so the low W bits hold it exactly.
            qw_q  <= quo_nx[W-1:0];
            quo_q <= na_q;
            rem_q <= '0;
            cnt_q <= '0;
          end else begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DIV_ACC: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          cnt_q <= last_iter ? 4'd0 : cnt_q + 4'd1;
        end
        COMMIT: begin
          wpm_avg_q <= qw_q;
          acc_avg_q <= quo_q[W-1:0];
          if (wpm_lat_q > wpm_best_q) wpm_best_q <= wpm_lat_q;
          if (acc_lat_q > acc_best_q) acc_best_q <= acc_lat_q;
          if (rounds_q != '1) rounds_q <= rounds_q + CNT_W'(1);
          upd_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wpm_best  = wpm_best_q;
  assign wpm_avg   = wpm_avg_q;
  assign acc_best  = acc_best_q;
  assign acc_avg   = acc_avg_q;
  assign rounds    = rounds_q;
  assign upd_valid = upd_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_stats_update_ctrl.sv
// Bench for stats_update_ctrl. A cycle-level reference model derives the
// expected outputs from the update rules with plain integer arithmetic. The
// outputs are compared on every falling edge. Literal values pin the scenarios
// described for the block.
module tb_stats_update_ctrl;
  localparam int W = 10, CNT_W = 5, LAT = 33, MAXR = 31;

  logic clk = 1'b0, rst = 1'b0, round_done = 1'b0, clear_stats = 1'b0;
  logic [W-1:0] wpm = '0, acc = '0;
  logic [W-1:0] wpm_best, wpm_avg, acc_best, acc_avg;
  logic [CNT_W-1:0] rounds;
  logic busy, upd_valid, overrun;

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  stats_update_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .round_done(round_done), .clear_stats(clear_stats),
    .wpm(wpm), .acc(acc), .wpm_best(wpm_best), .wpm_avg(wpm_avg),
    .acc_best(acc_best), .acc_avg(acc_avg), .rounds(rounds), .busy(busy),
    .upd_valid(upd_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an update started at edge st commits at edge st+LAT.
  int cyc, st, m_pend, m_rounds, m_wa, m_aa, m_wb, m_ab, m_ov, m_upd, lat_w, lat_a, prev_rd;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= 0; st <= 0; m_pend <= 0; m_rounds <= 0; m_wa <= 0; m_aa <= 0;
      m_wb <= 0; m_ab <= 0; m_ov <= 0; m_upd <= 0; lat_w <= 0; lat_a <= 0; prev_rd <= 0;
    end else begin : model
      int c, n, pend;
      bit busy_before, sv;
      c = cyc + 1;
      cyc <= c;
      busy_before = (m_pend != 0) && (c >= st + 2);
      sv = round_done && (prev_rd == 0);
      prev_rd <= int'(round_done);
      m_upd <= 0;
      pend = m_pend;
      if (clear_stats) begin
        m_pend <= 0; m_rounds <= 0; m_wa <= 0; m_aa <= 0; m_wb <= 0; m_ab <= 0; m_ov <= 0;
      end else begin
        if (m_pend != 0 && c == st + LAT) begin
          n = m_rounds;
          m_wa <= (m_wa * n + lat_w) / (n + 1);
          m_aa <= (m_aa * n + lat_a) / (n + 1);
          if (lat_w > m_wb) m_wb <= lat_w;
          if (lat_a > m_ab) m_ab <= lat_a;
          m_rounds <= (n < MAXR) ? n + 1 : MAXR;
          m_upd <= 1;
          pend = 0;
        end
        if (sv) begin
          if (busy_before) m_ov <= 1;
          else begin
            pend = 1; st <= c; lat_w <= int'(wpm); lat_a <= int'(acc);
          end
        end
        m_pend <= pend;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wpm_avg", int'(wpm_avg), m_wa);
      chk("acc_avg", int'(acc_avg), m_aa);
      chk("wpm_best", int'(wpm_best), m_wb);
      chk("acc_best", int'(acc_best), m_ab);
      chk("rounds", int'(rounds), m_rounds);
      chk("upd_valid", int'(upd_valid), m_upd);
      chk("overrun", int'(overrun), m_ov);
      chk("busy", int'(busy), int'((m_pend != 0) && (cyc >= st + 1)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One full round: rise, alter inputs after capture, stay high past commit, then fall.
  task automatic do_round(input int w, input int a);
    wpm = W'(w); acc = W'(a); round_done = 1'b1;
    tick(4);
    wpm = W'($urandom_range(1023)); acc = W'($urandom_range(1023));
    tick(40);
    round_done = 1'b0;
    tick(2);
  endtask

  initial begin
    tick(3);
    cmp_en = 1'b1;
    chk("reset rounds", int'(rounds), 0);
    chk("reset wpm_avg", int'(wpm_avg), 0);
    chk("reset busy", int'(busy), 0);
    rst = 1'b1;
    tick(2);

    do_round(60, 95);
    chk("r1 wpm_avg", int'(wpm_avg), 60);  chk("r1 acc_avg", int'(acc_avg), 95);
    chk("r1 wpm_best", int'(wpm_best), 60); chk("r1 rounds", int'(rounds), 1);
    do_round(41, 80);
    chk("r2 wpm_avg", int'(wpm_avg), 50);  chk("r2 acc_avg", int'(acc_avg), 87);
    chk("r2 wpm_best", int'(wpm_best), 60); chk("r2 acc_best", int'(acc_best), 95);
    do_round(90, 99);
    chk("r3 wpm_avg", int'(wpm_avg), 63);  chk("r3 acc_avg", int'(acc_avg), 91);
    chk("r3 wpm_best", int'(wpm_best), 90); chk("r3 acc_best", int'(acc_best), 99);
    chk("r3 rounds", int'(rounds), 3);

    // Saturation: 31 rounds of 100, then a zero round.
    clear_stats = 1'b1; tick(1); clear_stats = 1'b0; tick(1);
    for (int i = 0; i < 31; i++) do_round(100, 50);
    chk("sat31 rounds", int'(rounds), 31);
    do_round(0, 50);
    chk("sat rounds", int'(rounds), 31); chk("sat wpm_avg", int'(wpm_avg), 96);
    chk("sat wpm_best", int'(wpm_best), 100); chk("sat acc_avg", int'(acc_avg), 50);

    // Held level gives one update; a re-pulse while busy sets overrun.
    clear_stats = 1'b1; tick(1); clear_stats = 1'b0; tick(1);
    wpm = 10'd70; acc = 10'd70; round_done = 1'b1;
    tick(10); round_done = 1'b0; tick(1); round_done = 1'b1;
    tick(189); round_done = 1'b0; tick(2);
    chk("hold rounds", int'(rounds), 1); chk("hold overrun", int'(overrun), 1);
    chk("hold wpm_avg", int'(wpm_avg), 70);

    // Clear during the accuracy division aborts everything.
    wpm = 10'd55; acc = 10'd66; round_done = 1'b1;
    tick(23); clear_stats = 1'b1; tick(1); clear_stats = 1'b0;
    chk("clr busy", int'(busy), 0); chk("clr wpm_best", int'(wpm_best), 0);
    chk("clr overrun", int'(overrun), 0);
    tick(20); round_done = 1'b0; tick(2);
    chk("clr rounds", int'(rounds), 0);

    // Reset during the WPM division.
    do_round(20, 30);
    wpm = 10'd99; acc = 10'd99; round_done = 1'b1;
    tick(8); rst = 1'b0; round_done = 1'b0; tick(2);
    chk("rst rounds", int'(rounds), 0); chk("rst busy", int'(busy), 0);
    chk("rst wpm_avg", int'(wpm_avg), 0);
    rst = 1'b1; tick(40);
    chk("rst no commit", int'(rounds), 0);

    // Rise coincident with clear: no update starts.
    do_round(20, 30);
    wpm = 10'd44; acc = 10'd44; round_done = 1'b1; clear_stats = 1'b1;
    tick(1); clear_stats = 1'b0; tick(3);
    chk("coinc busy", int'(busy), 0);
    tick(40); round_done = 1'b0; tick(2);
    chk("coinc rounds", int'(rounds), 0);

    do_round(10, 20);
    chk("final rounds", int'(rounds), 1); chk("final wpm_avg", int'(wpm_avg), 10);
    chk("final acc_avg", int'(acc_avg), 20);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
